// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO drain controller: state encoding and width helper.
package fifo_drain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } drain_state_e;

  // Ceiling log2 with a floor of one bit, for sizing counters that must hold v-1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/fifo_drain_ctrl_drain_timer.sv
// Loadable down-counter that stops at zero; done_c flags the terminal count.
module fifo_drain_ctrl_drain_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-domain FIFO consumer: pops one word at a time and hands it to a byte-serial
// transmitter with a valid pulse, tracks the transmitter busy line, retries on ack
// timeout and optionally idles for a fixed gap after each word.
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned GAP_CYC = 0,
  parameter int unsigned ACK_TO  = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_rempty,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_rinc,
  output logic [WIDTH-1:0] o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_busy,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int unsigned ACK_W    = clog2_min1(ACK_TO);
  localparam int unsigned GAP_W    = clog2_min1(GAP_CYC + 1);
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? (GAP_CYC - 1) : 0;
  localparam logic        HAS_GAP  = (GAP_CYC > 0);

  drain_state_e state;
  logic         ack_load;
  logic         gap_load;
  logic         ack_done_c;
  logic         gap_done_c;

  // Decide when a valid pulse is issued (which also restarts the ack timer) and when the gap starts.
  // Valid is registered, so the pulse is launched from the edge that leaves POP/SEND, or from the
  // timeout edge in WAIT_ACK, which lets it appear one cycle after the pop strobe.
  always_comb begin
    ack_load = 1'b0;
    gap_load = 1'b0;
    case (state)
      ST_POP, ST_SEND: ack_load = !i_tx_busy;
      ST_WAIT_ACK:     ack_load = !i_tx_busy && ack_done_c;
      ST_WAIT_DONE:    gap_load = !i_tx_busy && HAS_GAP;
      default: ;
    endcase
  end

  fifo_drain_ctrl_drain_timer #(.W(ACK_W)) u_ack_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (ack_load),
    .dec      (state == ST_WAIT_ACK),
    .load_val (ACK_W'(ACK_TO - 1)),
    .done_c   (ack_done_c)
  );

  fifo_drain_ctrl_drain_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (gap_load),
    .dec      (state == ST_GAP),
    .load_val (GAP_W'(GAP_LOAD)),
    .done_c   (gap_done_c)
  );

  // Drain FSM with registered strobes, capture register and completed-word counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_rinc     <= 1'b0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_tx_data  <= '0;
      o_word_cnt <= '0;
    end else begin
      o_rinc     <= 1'b0;
      o_tx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_en && !i_rempty) begin
            state  <= ST_POP;
            o_rinc <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        ST_POP: begin
          o_tx_data  <= i_rd_data;
          o_tx_valid <= ack_load;
          state      <= ack_load ? ST_WAIT_ACK : ST_SEND;
        end
        ST_SEND: begin
          if (ack_load) begin
            o_tx_valid <= 1'b1;
            state      <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Timeout retry re-pulses the same captured word without another pop.
          if (i_tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (ack_load) begin
            o_tx_valid <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) begin
            o_word_cnt <= o_word_cnt + CNT_W'(1);
            state      <= HAS_GAP ? ST_GAP : ST_IDLE;
            o_busy     <= HAS_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done_c) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
